// File: rtl/qam16_demap_prbs_checker_if.sv
// Symbol-rate I/Q sample bus feeding the 16-QAM demapper.
// One sample pair per valid cycle, no back-pressure.
interface qam16_demap_prbs_checker_if #(
    parameter int DATA_WIDTH = 12
);
    logic signed [DATA_WIDTH-1:0] i_in;
    logic signed [DATA_WIDTH-1:0] q_in;
    logic                         in_valid;

    modport master (output i_in, output q_in, output in_valid);
    modport slave  (input  i_in, input  q_in, input  in_valid);
endinterface

// File: rtl/qam16_demap_prbs_checker.sv
// 16-QAM hard-decision demapper followed by a PRBS-23 replica checker.
// Stage 1 slices I/Q into Gray-coded bits; stage 2 hunts/verifies/locks a
// local replica (b[n] = b[n-23] ^ b[n-18]) and accumulates BER counters.
module qam16_demap_prbs_checker #(
    parameter int DATA_WIDTH  = 12,
    parameter int SLICE_THR   = 1296,
    parameter int HUNT_SYMS   = 6,
    parameter int VERIFY_SYMS = 16,
    parameter int WIN_SYMS    = 256,
    parameter int LOSS_THR    = 32,
    parameter int CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    qam16_demap_prbs_checker_if.slave rx,
    output logic [3:0]               sym_bits,
    output logic                     sym_valid,
    output logic [1:0]               state_o,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [CNT_W-1:0]         bit_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [7:0]               loss_cnt
);

    localparam int FILL_W = $clog2(HUNT_SYMS + 1);
    localparam int VER_W  = $clog2(VERIFY_SYMS + 1);
    localparam int WSYM_W = $clog2(WIN_SYMS + 1);
    localparam int WERR_W = $clog2(4 * WIN_SYMS + 1);

    localparam logic signed [DATA_WIDTH-1:0] THR_P = DATA_WIDTH'(SLICE_THR);
    localparam logic signed [DATA_WIDTH-1:0] THR_N = -THR_P;
    localparam logic signed [DATA_WIDTH-1:0] ZERO  = '0;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [22:0]         hist, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [VER_W-1:0]    ver_q, ver_d;
    logic [WSYM_W-1:0]   wsym_q, wsym_d;
    logic [WERR_W-1:0]   werr_q, werr_d;
    logic [WERR_W-1:0]   werr_sum;
    logic                pulse_d;
    logic [2:0]          bit_inc;
    logic [2:0]          err_inc;
    logic                loss_inc;
    logic [3:0]          pred;
    logic [3:0]          diff;
    logic [2:0]          nerr;

    function automatic logic [1:0] slice(input logic signed [DATA_WIDTH-1:0] x);
        if (x >= THR_P)      return 2'b10;
        else if (x >= ZERO)  return 2'b11;
        else if (x >= THR_N) return 2'b01;
        else                 return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0]       inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // All four predictions come from pre-symbol history since the shortest tap lag (18) exceeds 4.
    assign pred     = {hist[22] ^ hist[17], hist[21] ^ hist[16],
                       hist[20] ^ hist[15], hist[19] ^ hist[14]};
    assign diff     = sym_bits ^ pred;
    assign nerr     = 3'(diff[0]) + 3'(diff[1]) + 3'(diff[2]) + 3'(diff[3]);
    assign werr_sum = werr_q + WERR_W'(nerr);

    assign state_o  = state;
    assign locked   = (state == LOCK);

    // Stage 1: register the sliced symbol bits, I -> {b3,b2}, Q -> {b1,b0}.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_bits  <= '0;
            sym_valid <= 1'b0;
        end else begin
            sym_valid <= rx.in_valid;
            if (rx.in_valid) begin
                sym_bits <= {slice(rx.i_in), slice(rx.q_in)};
            end
        end
    end

    // Stage 2 next-state: HUNT/VERIFY/LOCK sequencing, history update and count requests.
    always_comb begin
        state_d  = state;
        hist_d   = hist;
        fill_d   = fill_q;
        ver_d    = ver_q;
        wsym_d   = wsym_q;
        werr_d   = werr_q;
        pulse_d  = 1'b0;
        bit_inc  = '0;
        err_inc  = '0;
        loss_inc = 1'b0;
        if (sym_valid) begin
            unique case (state)
                HUNT: begin
                    hist_d = {hist[18:0], sym_bits};
                    if (fill_q == FILL_W'(HUNT_SYMS - 1)) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        ver_d   = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    hist_d = {hist[18:0], pred};
                    if (|diff) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else if (ver_q == VER_W'(VERIFY_SYMS - 1)) begin
                        state_d = LOCK;
                        wsym_d  = '0;
                        werr_d  = '0;
                    end else begin
                        ver_d = ver_q + VER_W'(1);
                    end
                end
                LOCK: begin
                    // Replica free-runs on its own predictions so channel errors never propagate.
                    hist_d  = {hist[18:0], pred};
                    bit_inc = 3'd4;
                    err_inc = nerr;
                    pulse_d = |diff;
                    if (wsym_q == WSYM_W'(WIN_SYMS - 1)) begin
                        wsym_d = '0;
                        werr_d = '0;
                        if (werr_sum > WERR_W'(LOSS_THR)) begin
                            state_d  = HUNT;
                            fill_d   = '0;
                            loss_inc = 1'b1;
                        end
                    end else begin
                        wsym_d = wsym_q + WSYM_W'(1);
                        werr_d = werr_sum;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Stage 2 state register and control counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            hist      <= '0;
            fill_q    <= '0;
            ver_q     <= '0;
            wsym_q    <= '0;
            werr_q    <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_d;
            hist      <= hist_d;
            fill_q    <= fill_d;
            ver_q     <= ver_d;
            wsym_q    <= wsym_d;
            werr_q    <= werr_d;
            err_pulse <= pulse_d;
        end
    end

    // BER counters: saturating, clear overrides any same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bit_cnt  <= '0;
            err_cnt  <= '0;
            loss_cnt <= '0;
        end else begin
            bit_cnt <= sat_add(bit_cnt, bit_inc);
            err_cnt <= sat_add(err_cnt, err_inc);
            if (loss_inc && (loss_cnt != 8'hFF)) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_qam16_demap_prbs_checker.sv
// Directed bench for qam16_demap_prbs_checker: slicer sweep, PRBS-23 lock,
// error injection, window loss, VERIFY failure, clear and saturation.
module tb_qam16_demap_prbs_checker;

    localparam int SEQ_SYMS = 1700;
    localparam int SEQ_BITS = 4 * SEQ_SYMS;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [3:0]  sym_bits;
    logic        sym_valid;
    logic [1:0]  state_o;
    logic        locked;
    logic        err_pulse;
    logic [31:0] bit_cnt;
    logic [31:0] err_cnt;
    logic [7:0]  loss_cnt;

    logic [3:0]  s_sym_bits;
    logic        s_sym_valid;
    logic [1:0]  s_state_o;
    logic        s_locked;
    logic        s_err_pulse;
    logic [3:0]  s_bit_cnt;
    logic [3:0]  s_err_cnt;
    logic [7:0]  s_loss_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned pulse_cnt = 0;
    int unsigned sp = 0;
    logic        seq [0:SEQ_BITS-1];

    qam16_demap_prbs_checker_if #(.DATA_WIDTH(12)) rx ();

    qam16_demap_prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .rx        (rx),
        .sym_bits  (sym_bits),
        .sym_valid (sym_valid),
        .state_o   (state_o),
        .locked    (locked),
        .err_pulse (err_pulse),
        .bit_cnt   (bit_cnt),
        .err_cnt   (err_cnt),
        .loss_cnt  (loss_cnt)
    );

    qam16_demap_prbs_checker #(.CNT_W(4)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .rx        (rx),
        .sym_bits  (s_sym_bits),
        .sym_valid (s_sym_valid),
        .state_o   (s_state_o),
        .locked    (s_locked),
        .err_pulse (s_err_pulse),
        .bit_cnt   (s_bit_cnt),
        .err_cnt   (s_err_cnt),
        .loss_cnt  (s_loss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #1;
        if (err_pulse) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic signed [11:0] amp(input logic [1:0] b);
        case (b)
            2'b10:   return 12'sd1943;
            2'b11:   return 12'sd648;
            2'b01:   return -12'sd648;
            default: return -12'sd1943;
        endcase
    endfunction

    task automatic send(input logic [3:0] b);
        rx.i_in     = amp(b[3:2]);
        rx.q_in     = amp(b[1:0]);
        rx.in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        rx.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_prbs(input int unsigned n, input int unsigned n_err, input logic [3:0] mask);
        logic [3:0] b;
        for (int unsigned i = 0; i < n; i++) begin
            b = {seq[4*sp], seq[4*sp+1], seq[4*sp+2], seq[4*sp+3]};
            if (i < n_err) b = b ^ mask;
            send(b);
            sp++;
        end
    endtask

    initial begin
        int       sv [8] = '{-2048, -1297, -1296, -1, 0, 1295, 1296, 2047};
        logic [1:0] se [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10};

        for (int n = 0; n < SEQ_BITS; n++) begin
            seq[n] = (n < 23) ? 1'b1 : (seq[n-23] ^ seq[n-18]);
        end

        rst = 1'b1;
        clear = 1'b0;
        rx.i_in = '0;
        rx.q_in = '0;
        rx.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sym_valid", 32'(sym_valid), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_bit_cnt", bit_cnt, 32'd0);
        check("rst_loss_cnt", 32'(loss_cnt), 32'd0);
        rst = 1'b0;

        // Slicer sweep, I ascending and Q descending to exercise the bit packing.
        for (int k = 0; k < 8; k++) begin
            rx.i_in     = 12'(sv[k]);
            rx.q_in     = 12'(sv[7-k]);
            rx.in_valid = 1'b1;
            @(negedge clk);
            check("slice_valid", 32'(sym_valid), 32'd1);
            check("slice_bits", 32'(sym_bits), 32'({se[k], se[7-k]}));
        end
        idle();
        check("gap_valid", 32'(sym_valid), 32'd0);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Clean PRBS from all-ones seed, back to back.
        send_prbs(22, 0, 4'b0000);
        check("pre_lock_state", 32'(state_o), 32'd1);
        check("pre_lock_locked", 32'(locked), 32'd0);
        idle();
        check("lock_locked", 32'(locked), 32'd1);
        check("lock_state", 32'(state_o), 32'd2);
        check("lock_bit_cnt0", bit_cnt, 32'd0);

        send_prbs(1000, 0, 4'b0000);
        idle();
        check("clean_bit_cnt", bit_cnt, 32'd4000);
        check("clean_err_cnt", err_cnt, 32'd0);
        check("clean_pulses", pulse_cnt, 32'd0);

        // Single b2 flip.
        send_prbs(11, 1, 4'b0100);
        idle();
        check("flip_err_cnt", err_cnt, 32'd1);
        check("flip_pulses", pulse_cnt, 32'd1);
        check("flip_locked", 32'(locked), 32'd1);

        // Align to a window boundary (1024 LOCK symbols), then 32 errors: no loss.
        send_prbs(13, 0, 4'b0000);
        send_prbs(256, 32, 4'b1000);
        idle();
        check("win32_locked", 32'(locked), 32'd1);
        check("win32_err_cnt", err_cnt, 32'd33);

        // 33 errors: lock dropped exactly at the window's last symbol.
        send_prbs(255, 33, 4'b1000);
        idle();
        check("win33_pre_end", 32'(locked), 32'd1);
        send_prbs(1, 0, 4'b0000);
        idle();
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_state", 32'(state_o), 32'd0);
        check("loss_cnt", 32'(loss_cnt), 32'd1);
        check("loss_err_cnt", err_cnt, 32'd66);
        check("loss_bit_cnt", bit_cnt, 32'd6144);
        check("small_err_sat", 32'(s_err_cnt), 32'd15);
        check("small_bit_sat", 32'(s_bit_cnt), 32'd15);

        send_prbs(21, 0, 4'b0000);
        idle();
        check("relock_21", 32'(locked), 32'd0);
        send_prbs(1, 0, 4'b0000);
        idle();
        check("relock_22", 32'(locked), 32'd1);
        check("relock_bit_cnt", bit_cnt, 32'd6144);

        // clear coincides with an error symbol's stage-2 update.
        send_prbs(1, 1, 4'b0100);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        check("clear_bit_cnt", bit_cnt, 32'd0);
        check("clear_err_cnt", err_cnt, 32'd0);
        check("clear_loss_cnt", 32'(loss_cnt), 32'd0);
        check("clear_locked", 32'(locked), 32'd1);
        check("clear_pulses", pulse_cnt, 32'd67);

        // Saturation with overshooting add of 4 (4-bit counter: 12 -> 15).
        send_prbs(3, 0, 4'b0000);
        idle();
        check("sat_small_12", 32'(s_bit_cnt), 32'd12);
        send_prbs(1, 0, 4'b0000);
        idle();
        check("sat_small_15", 32'(s_bit_cnt), 32'd15);
        send_prbs(1, 0, 4'b0000);
        idle();
        check("sat_small_hold", 32'(s_bit_cnt), 32'd15);
        check("sat_big_bit_cnt", bit_cnt, 32'd20);

        // Reset mid-operation with a symbol in flight.
        send_prbs(1, 0, 4'b0000);
        rst = 1'b1;
        idle();
        idle();
        check("midrst_valid", 32'(sym_valid), 32'd0);
        check("midrst_state", 32'(state_o), 32'd0);
        check("midrst_bit_cnt", bit_cnt, 32'd0);
        rst = 1'b0;

        // Error on the 5th VERIFY symbol.
        send_prbs(6, 0, 4'b0000);
        idle();
        check("ver_entry", 32'(state_o), 32'd1);
        send_prbs(4, 0, 4'b0000);
        send_prbs(1, 1, 4'b0001);
        idle();
        check("ver_fail_state", 32'(state_o), 32'd0);
        check("ver_fail_err", err_cnt, 32'd0);
        send_prbs(21, 0, 4'b0000);
        idle();
        check("ver_relock_21", 32'(locked), 32'd0);
        send_prbs(1, 0, 4'b0000);
        idle();
        check("ver_relock_22", 32'(locked), 32'd1);
        check("ver_relock_err", err_cnt, 32'd0);
        check("ver_relock_bits", bit_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
